// File: rtl/mm_pkg.sv
// Shared types and helpers for the mastermind engine: FSM states, coin codes
// and the width rule for the match-count outputs.
package mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_GUESS = 2'd2,
    ST_GRADE = 2'd3
  } mm_state_e;

  localparam logic [1:0] COIN_NONE  = 2'b00;
  localparam logic [1:0] COIN_ONE   = 2'b01;
  localparam logic [1:0] COIN_THREE = 2'b10;
  localparam logic [1:0] COIN_FIVE  = 2'b11;

  localparam logic [2:0] UNITS_NONE  = 3'd0;
  localparam logic [2:0] UNITS_ONE   = 3'd1;
  localparam logic [2:0] UNITS_THREE = 3'd3;
  localparam logic [2:0] UNITS_FIVE  = 3'd5;

  function automatic logic [2:0] coin_units(input logic [1:0] code);
    case (code)
      COIN_ONE:   return UNITS_ONE;
      COIN_THREE: return UNITS_THREE;
      COIN_FIVE:  return UNITS_FIVE;
      default:    return UNITS_NONE;
    endcase
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mm_grader.sv
// Combinational scorer: exact hits (znarly) and right-shape/wrong-slot hits (zood).
// Shape code 0 marks an empty slot and never counts as a match.
module mm_grader
  import mm_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SHAPE_W   = 3
) (
  input  logic [NUM_SLOTS*SHAPE_W-1:0] master,
  input  logic [NUM_SLOTS*SHAPE_W-1:0] guess,
  output logic [cnt_w(NUM_SLOTS)-1:0]  znarly,
  output logic [cnt_w(NUM_SLOTS)-1:0]  zood
);

  localparam int CW         = cnt_w(NUM_SLOTS);
  localparam int NUM_SHAPES = 1 << SHAPE_W;

  logic [CW-1:0] exact_s;
  logic [CW-1:0] common_s;
  logic [CW-1:0] in_guess_s;
  logic [CW-1:0] in_master_s;

  // Exact hits, then the per-shape overlap min(guess count, master count)
  always_comb begin
    exact_s     = '0;
    common_s    = '0;
    in_guess_s  = '0;
    in_master_s = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if ((guess[i*SHAPE_W +: SHAPE_W] != '0) &&
          (guess[i*SHAPE_W +: SHAPE_W] == master[i*SHAPE_W +: SHAPE_W])) begin
        exact_s = exact_s + CW'(1);
      end else begin
        exact_s = exact_s;
      end
    end
    for (int s = 1; s < NUM_SHAPES; s++) begin
      in_guess_s  = '0;
      in_master_s = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (guess[i*SHAPE_W +: SHAPE_W] == SHAPE_W'(s)) in_guess_s = in_guess_s + CW'(1);
        else in_guess_s = in_guess_s;
        if (master[i*SHAPE_W +: SHAPE_W] == SHAPE_W'(s)) in_master_s = in_master_s + CW'(1);
        else in_master_s = in_master_s;
      end
      common_s = common_s + ((in_guess_s < in_master_s) ? in_guess_s : in_master_s);
    end
  end

  assign znarly = exact_s;
  assign zood   = common_s - exact_s;

endmodule

// File: rtl/mastermind_engine.sv
// Coin-operated Mastermind game engine: credit/game accounting, master load,
// edge-triggered grading. Define MM_MASTER_REVEAL_EN to expose master_pattern.
module mastermind_engine
  import mm_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int SHAPE_W    = 3,
  parameter int MAX_ROUNDS = 8,
  parameter int GAME_PRICE = 4,
  parameter int MAX_GAMES  = 7
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [1:0]                            coin_value,
  input  logic                                  coin_inserted,
  input  logic                                  start_game,
  input  logic [SHAPE_W-1:0]                    load_shape,
  input  logic [$clog2(NUM_SLOTS)-1:0]          shape_location,
  input  logic                                  load_shape_now,
  input  logic [NUM_SLOTS*SHAPE_W-1:0]          guess,
  input  logic                                  grade_it,
  output logic [cnt_w(NUM_SLOTS)-1:0]           znarly,
  output logic [cnt_w(NUM_SLOTS)-1:0]           zood,
  output logic                                  grade_valid,
  output logic [3:0]                            round_number,
  output logic [3:0]                            num_games,
  output logic                                  game_won
`ifdef MM_MASTER_REVEAL_EN
  ,
  output logic [NUM_SLOTS*SHAPE_W-1:0]          master_pattern
`endif
);

  localparam int CW = cnt_w(NUM_SLOTS);
  localparam logic [4:0] PRICE = 5'(GAME_PRICE);

  mm_state_e                    state_q, state_d;
  logic [4:0]                   credit_q, credit_d;
  logic [3:0]                   games_q, games_d;
  logic [NUM_SLOTS*SHAPE_W-1:0] master_q, master_d;
  logic [3:0]                   round_q, round_d;
  logic [CW-1:0]                znarly_q, znarly_d, zood_q, zood_d;
  logic                         valid_q, valid_d, won_q, won_d, grade_q;

  logic [CW-1:0] g_znarly_s, g_zood_s;
  logic          take_s, all_full_s, load_ok_s;
  logic [4:0]    sum_s;
  logic [3:0]    eff_games_s;

  mm_grader #(.NUM_SLOTS(NUM_SLOTS), .SHAPE_W(SHAPE_W)) u_grader (
    .master (master_q),
    .guess  (guess),
    .znarly (g_znarly_s),
    .zood   (g_zood_s)
  );

  // Slot occupancy and legality of the requested load
  always_comb begin
    all_full_s = 1'b1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (master_q[i*SHAPE_W +: SHAPE_W] == '0) all_full_s = 1'b0;
      else all_full_s = all_full_s;
    end
    load_ok_s = load_shape_now && (load_shape != '0) && (int'(shape_location) < NUM_SLOTS) &&
                (master_q[int'(shape_location)*SHAPE_W +: SHAPE_W] == '0);
  end

  // Game FSM next state and game-scoped registers
  always_comb begin
    state_d  = state_q;
    master_d = master_q;
    round_d  = round_q;
    znarly_d = znarly_q;
    zood_d   = zood_q;
    valid_d  = 1'b0;
    won_d    = won_q;
    take_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_game && (games_q != 4'd0)) begin
          take_s   = 1'b1;
          state_d  = ST_LOAD;
          master_d = '0;
          round_d  = 4'd0;
          won_d    = 1'b0;
          znarly_d = '0;
          zood_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (load_ok_s) master_d[int'(shape_location)*SHAPE_W +: SHAPE_W] = load_shape;
        else master_d = master_q;
        if (all_full_s) state_d = ST_GUESS;
        else state_d = ST_LOAD;
      end
      ST_GUESS: begin
        if (grade_it && !grade_q) state_d = ST_GRADE;
        else state_d = ST_GUESS;
      end
      ST_GRADE: begin
        valid_d  = 1'b1;
        znarly_d = g_znarly_s;
        zood_d   = g_zood_s;
        round_d  = round_q + 4'd1;
        if (g_znarly_s == CW'(NUM_SLOTS)) begin
          won_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (round_d == 4'(MAX_ROUNDS)) begin
          won_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GUESS;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Coin accounting; a start in the same cycle is netted before the purchase test
  always_comb begin
    sum_s       = credit_q + {2'b00, (coin_inserted ? coin_units(coin_value) : 3'd0)};
    eff_games_s = games_q - {3'b000, take_s};
    if ((sum_s >= PRICE) && (eff_games_s < 4'(MAX_GAMES))) begin
      credit_d = sum_s - PRICE;
      games_d  = eff_games_s + 4'd1;
    end else if (sum_s >= PRICE) begin
      credit_d = PRICE - 5'd1;
      games_d  = eff_games_s;
    end else begin
      credit_d = sum_s;
      games_d  = eff_games_s;
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      credit_q <= 5'd0;
      games_q  <= 4'd0;
      master_q <= '0;
      round_q  <= 4'd0;
      znarly_q <= '0;
      zood_q   <= '0;
      valid_q  <= 1'b0;
      won_q    <= 1'b0;
      grade_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      games_q  <= games_d;
      master_q <= master_d;
      round_q  <= round_d;
      znarly_q <= znarly_d;
      zood_q   <= zood_d;
      valid_q  <= valid_d;
      won_q    <= won_d;
      grade_q  <= grade_it;
    end
  end

  assign znarly       = znarly_q;
  assign zood         = zood_q;
  assign grade_valid  = valid_q;
  assign round_number = round_q;
  assign num_games    = games_q;
  assign game_won     = won_q;

`ifdef MM_MASTER_REVEAL_EN
  assign master_pattern = (state_q == ST_IDLE) ? '0 : master_q;
`endif

endmodule

// File: doc/mastermind_engine.md
MASTERMIND_ENGINE -- requirements
Module: mastermind_engine

Interface
REQ-001 Parameter NUM_SLOTS, default 4, number of pattern slots (2..8).
REQ-002 Parameter SHAPE_W, default 3, bits per shape code; code 0 = empty slot.
REQ-003 Parameter MAX_ROUNDS, default 8, guesses allowed per game (1..15).
REQ-004 Parameter GAME_PRICE, default 4, coin units per game credit (1..15).
REQ-005 Parameter MAX_GAMES, default 7, saturation value of the game credit count (1..15).
REQ-006 Ports, one clock; reset is asynchronous and active-low:
 clock  in  1  rising-edge clock
 reset  in  1  asynchronous, active-low reset
 coin_value  in  2  01=1, 10=3, 11=5, 00=0 units
 coin_inserted  in  1  one-cycle coin strobe
 start_game  in  1  request a new game
 load_shape  in  SHAPE_W  shape to load
 shape_location  in  $clog2(NUM_SLOTS)  target slot
 load_shape_now  in  1  load strobe
 guess  in  NUM_SLOTS*SHAPE_W  guess; slot 0 in LSBs
 grade_it  in  1  grade request, rising-edge sensitive
 znarly  out  $clog2(NUM_SLOTS+1)  exact matches
 zood  out  $clog2(NUM_SLOTS+1)  right shape, wrong slot
 grade_valid  out  1  one-cycle pulse: znarly/zood updated
 round_number  out  4  graded guesses this game
 num_games  out  4  unused game credits
 game_won  out  1  last game won, sticky until next start

Function
REQ-007 Coin: credit += unit value on coin_inserted; when credit >= GAME_PRICE, subtract GAME_PRICE, num_games += 1, same cycle.
REQ-008 num_games saturates at MAX_GAMES; when saturated, credit still accumulates, capped at GAME_PRICE-1.
REQ-009 FSM states IDLE, LOAD, GUESS, GRADE.
REQ-010 IDLE->LOAD on start_game && num_games>0: num_games -= 1, master cleared, round_number=0, game_won=0, znarly/zood=0.
REQ-011 start_game with num_games==0 is ignored; start_game outside IDLE is ignored.
REQ-012 Coin increment and game decrement in the same cycle net to zero change.
REQ-013 LOAD: load_shape_now writes load_shape to shape_location only if that slot is 0 and load_shape!=0; otherwise no change.
REQ-014 LOAD->GUESS on the cycle after all slots are non-zero.
REQ-015 GUESS: grade_it 0->1 transition (registered edge detect) -> GRADE; a held-high grade_it grades once.
REQ-016 GRADE lasts one cycle: register znarly, zood; pulse grade_valid; round_number += 1. Latency: edge-detect cycle plus one.
REQ-017 znarly = count of slots with guess==master.
REQ-018 zood = sum over non-zero shapes of min(count in guess, count in master) minus znarly.
REQ-019 znarly==NUM_SLOTS: game_won=1, ->IDLE. Else round_number==MAX_ROUNDS: ->IDLE, game_won=0. Else ->GUESS.
REQ-020 Guess slots equal 0 never match.
REQ-021 Coins are accepted in every state.

Reset
REQ-022 Asserted reset: state=IDLE, credit=0, num_games=0, master=0, round_number=0, znarly=zood=0, grade_valid=0, game_won=0, edge register=0.
REQ-023 Reset mid-game aborts the game; the consumed credit is not refunded.

Configuration
REQ-024 MM_MASTER_REVEAL_EN defined: output master_pattern[NUM_SLOTS*SHAPE_W] carries the master in LOAD/GUESS/GRADE and 0 in IDLE. Not defined: port and logic absent.

Structure
REQ-025 Package mm_pkg holds the state enum, coin encodings/unit values, and a width function for count outputs.
REQ-026 Combinational sub-module mm_grader(master, guess -> znarly, zood) implements REQ-017..020; the top registers its outputs.

Verification
REQ-027 Defaults; coins 11, 01 -> num_games=1, credit=2 after the second coin.
REQ-028 Seven 4-unit credits plus one more coin -> num_games=7; credit <= 3.
REQ-029 Master {slot3..0}={1,2,3,4}; guess {1,2,4,3}; grade_it rise -> grade_valid two cycles later, znarly=2, zood=2, round_number=1.
REQ-030 Master {1,1,2,2}, guess {2,2,1,5} -> znarly=0, zood=3; exact guess -> znarly=4, game_won=1, IDLE.
REQ-031 Eight wrong guesses -> round_number=8, IDLE, game_won=0; a ninth grade_it is ignored.
REQ-032 Load into an occupied slot -> unchanged. Reset low mid-GUESS -> all outputs at reset values.
